therm_sum_decoder: RTL
======================

Name: therm_sum_decoder

Overview:
- Consumer end of the sorter-network datapath: accepts N-bit thermometer words as produced by the sorter blocks (ones packed toward the MSB).
- Converts each word to a binary ones-count and checks it for bubble errors.
- Accumulates counts over a framed stream and presents one per-frame result (sum, word count, error/overflow flags) on a valid/ready output.
- Sits between the sorter stage and downstream binary-count consumers.

Parameters:
N, 4, input thermometer word width (N >= 2)
CNT_W, 8, width of the sum and word-count accumulators (CNT_W >= $clog2(N+1))

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input word valid
in_ready  output  1  block can accept a word
in_therm  input  N  thermometer word; ones are expected contiguous from bit N-1 downward
in_last  input  1  marks the final word of a frame; qualified by in_valid
out_valid  output  1  frame result valid
out_ready  input  1  downstream accepts result
out_sum  output  CNT_W  saturating sum of per-word ones-counts over the frame
out_words  output  CNT_W  saturating number of words in the frame
out_err  output  1  at least one word in the frame had a bubble
out_ovf  output  1  out_sum or out_words saturated during the frame

Behaviour:
- Reset, asynchronous on rst_n low:
  - state=ACC; out_valid=0; out_sum=0; out_words=0; out_err=0; out_ovf=0.
  - in_ready=1 after reset deasserts.
- Per-word decode (combinational):
  - cnt = popcount(in_therm), width $clog2(N+1).
  - bubble = 1 if any i in 0..N-2 has in_therm[i]=1 and in_therm[i+1]=0.
  - Examples: 4'b1100 -> cnt 2, bubble 0. 4'b1010 -> cnt 2, bubble 1. 4'b0000 -> cnt 0, bubble 0.
  - A bubbled word still contributes its popcount.
- State machine, two states:
  - ACC:
    - in_ready=1, out_valid=0.
    - On in_valid & in_ready (beat): sum <= sat(sum+cnt); words <= sat(words+1); err <= err | bubble; ovf <= ovf | (either add would exceed 2^CNT_W-1).
    - If in_last on the beat: go to DONE.
  - DONE:
    - in_ready=0, out_valid=1.
    - Outputs hold stable until out_ready.
    - On out_valid & out_ready: sum, words, err and ovf clear to 0; go to ACC.
- Latency: out_valid rises the cycle after the beat carrying in_last. The result includes that beat.
- Throughput:
  - One word per cycle within a frame.
  - At least one cycle with in_ready=0 between frames (the DONE cycle).
  - No input is accepted while a result is pending.
- Saturation: each accumulator clamps at 2^CNT_W-1 and never wraps. ovf is sticky for the frame.
- in_therm and in_last are ignored when in_valid=0 or in_ready=0.
- out_ready in ACC is a don't-care.
- Reset mid-frame or mid-DONE: the partial frame and any pending result are discarded; all outputs return to reset values.
- A single-beat frame (in_last on the first word) is legal.
- Outputs are registered. in_ready and out_valid are decoded directly from the state register, with no combinational path from inputs.

Decomposition:
- Shared package:
  - state enum {ACC, DONE}.
  - Function for the count width, $clog2(N+1).
  - Saturating-add helper function.
- Sub-module therm_decode (combinational, parameter N): in_therm -> cnt, bubble. It is reused wherever sorter outputs are checked.
- The top level holds the FSM and the accumulators.

Test Plan:
- Clean frame: 4'b1000, 4'b1100, 4'b1111 (last), out_ready=1 -> out_valid one cycle after the last beat; sum=7, words=3, err=0, ovf=0; in_ready low exactly one cycle.
- Bubble: frame 4'b1100, 4'b1010 (last) -> sum=4, words=2, err=1. The next clean frame 4'b1110 (last) reports err=0, sum=3.
- Backpressure:
  - Stimulus: after a frame ending in 4'b1111 (last), hold out_ready=0 for 5 cycles while in_valid=1.
  - Response: out_valid stays 1, outputs stay stable, in_ready stays 0, no words are accepted.
  - When out_ready rises, the handshake completes and ACC resumes the next cycle.
- Saturation (CNT_W=8): 64 words of 4'b1111, last on the 64th -> sum=255, words=64, ovf=1. Repeat with CNT_W=4 and 16 words of 4'b0000 -> words=15, ovf=1, sum=0.
- Edge frames: a single word 4'b0000 with in_last -> sum=0, words=1, err=0. in_valid gaps inside a frame do not change the totals.
- Reset: assert rst_n=0 asynchronously mid-frame (after 2 beats) and again during DONE -> outputs are 0 immediately. After release, frame 4'b1100 (last) gives sum=2, words=1.

Source files
------------

// File: rtl/therm_sum_decoder_pkg.sv
// Shared types and helpers for the thermometer-sum decoder.
// Saturating arithmetic is done at 32 bits and clamped to the caller's width.
package therm_sum_decoder_pkg;

  localparam logic [0:0] ST_ACC  = 1'b0;
  localparam logic [0:0] ST_DONE = 1'b1;

  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  // Supports widths up to 32.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] s;
    logic [32:0] m;
    s = {1'b0, a} + {1'b0, b};
    m = (33'd1 << w) - 33'd1;
    return (s > m) ? m[31:0] : s[31:0];
  endfunction

  function automatic logic add_ovf(input logic [31:0] a, input logic [31:0] b,
                                   input int unsigned w);
    logic [32:0] s;
    logic [32:0] m;
    s = {1'b0, a} + {1'b0, b};
    m = (33'd1 << w) - 33'd1;
    return s > m;
  endfunction

endpackage

// File: rtl/therm_sum_decoder_decode.sv
// Combinational thermometer word check: ones-count plus bubble detection.
// A bubble is any set bit whose upper neighbour is clear.
module therm_decode
  import therm_sum_decoder_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]            in_therm,
  output logic [cnt_width(N)-1:0] cnt,
  output logic                    bubble
);

  localparam int unsigned CW = cnt_width(N);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < N; i++) begin
      cnt = cnt + CW'(in_therm[i]);
    end
  end

  always_comb begin
    bubble = 1'b0;
    for (int i = 0; i < N - 1; i++) begin
      bubble = bubble | (in_therm[i] & ~in_therm[i+1]);
    end
  end

endmodule

// File: rtl/therm_sum_decoder.sv
// Accumulates thermometer-word ones-counts over a framed stream and presents
// one saturating per-frame result on a valid/ready output.
module therm_sum_decoder
  import therm_sum_decoder_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_therm,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_words,
  output logic             out_err,
  output logic             out_ovf
);

  localparam int unsigned CW = cnt_width(N);

  logic [CW-1:0]    cnt;
  logic             bubble;
  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] words_q, words_d;
  logic             err_q, err_d;
  logic             ovf_q, ovf_d;
  logic             beat;

  therm_decode #(
    .N(N)
  ) u_decode (
    .in_therm(in_therm),
    .cnt     (cnt),
    .bubble  (bubble)
  );

  assign beat = in_valid & (state_q == ST_ACC);

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    words_d = words_q;
    err_d   = err_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_ACC: begin
        if (beat) begin
          sum_d   = CNT_W'(sat_add(32'(sum_q), 32'(cnt), CNT_W));
          words_d = CNT_W'(sat_add(32'(words_q), 32'd1, CNT_W));
          err_d   = err_q | bubble;
          ovf_d   = ovf_q | add_ovf(32'(sum_q), 32'(cnt), CNT_W)
                          | add_ovf(32'(words_q), 32'd1, CNT_W);
          if (in_last) state_d = ST_DONE;
        end
      end
      default: begin
        if (out_ready) begin
          sum_d   = '0;
          words_d = '0;
          err_d   = 1'b0;
          ovf_d   = 1'b0;
          state_d = ST_ACC;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACC;
      sum_q   <= '0;
      words_q <= '0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      words_q <= words_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == ST_ACC);
  assign out_valid = (state_q == ST_DONE);
  assign out_sum   = sum_q;
  assign out_words = words_q;
  assign out_err   = err_q;
  assign out_ovf   = ovf_q;

endmodule
